// File: rtl/gate_gen_pkg.sv
// Shared types and config clamping for the gate/pulse generator.
package gate_gen_pkg;

  localparam int unsigned GG_MAX_W      = 32;
  localparam int unsigned GG_MIN_PERIOD = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gate_state_t;

  typedef struct packed {
    logic [GG_MAX_W-1:0] period;
    logic [GG_MAX_W-1:0] high;
  } gate_cfg_t;

  // Period is raised to the legal minimum; high time must leave at least one low clock.
  function automatic gate_cfg_t clamp_cfg(input logic [GG_MAX_W-1:0] period,
                                          input logic [GG_MAX_W-1:0] high,
                                          input logic [GG_MAX_W-1:0] min_period);
    gate_cfg_t c;
    c.period = (period < min_period) ? min_period : period;
    c.high   = (high > (c.period - 32'd1)) ? (c.period - 32'd1) : high;
    return c;
  endfunction

endpackage

// File: rtl/gate_cfg_shadow.sv
// Pending/active config register pair: direct write when idle, deferred apply on a period boundary.
module gate_cfg_shadow
  import gate_gen_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MIN_PERIOD = GG_MIN_PERIOD,
  parameter int unsigned DEF_PERIOD = 2,
  parameter int unsigned DEF_HIGH   = 1
) (
  input  logic             sys_count_clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_idle,
  input  logic             i_boundary,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_high,
  output logic [CNT_W-1:0] o_act_period,
  output logic [CNT_W-1:0] o_act_high,
  output logic [CNT_W-1:0] o_nxt_high_c,
  output logic             o_cfg_ack
);

  gate_cfg_t        w_clamp;
  logic [CNT_W-1:0] w_eff_period;
  logic [CNT_W-1:0] w_eff_high;
  logic [CNT_W-1:0] w_act_period_nxt;
  logic [CNT_W-1:0] w_act_high_nxt;
  logic             w_apply;
  logic             w_idle_load;
  logic             w_run_load;

  logic [CNT_W-1:0] r_pend_period;
  logic [CNT_W-1:0] r_pend_high;
  logic             r_pend_vld;
  logic [CNT_W-1:0] r_act_period;
  logic [CNT_W-1:0] r_act_high;
  logic             r_cfg_ack;

  always_comb begin
    w_clamp = clamp_cfg(GG_MAX_W'(i_period), GG_MAX_W'(i_high), GG_MAX_W'(MIN_PERIOD));
  end

  assign w_eff_period = CNT_W'(w_clamp.period);
  assign w_eff_high   = CNT_W'(w_clamp.high);

  // Apply uses the pending flag as registered before this edge, so a load on the boundary waits a period.
  assign w_apply     = i_boundary & r_pend_vld;
  assign w_idle_load = i_idle & i_load;
  assign w_run_load  = i_load & ~i_idle;

  always_comb begin
    w_act_period_nxt = r_act_period;
    w_act_high_nxt   = r_act_high;
    if (w_apply) begin
      w_act_period_nxt = r_pend_period;
      w_act_high_nxt   = r_pend_high;
    end else if (w_idle_load) begin
      w_act_period_nxt = w_eff_period;
      w_act_high_nxt   = w_eff_high;
    end
  end

  always_ff @(posedge sys_count_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_period <= '0;
      r_pend_high   <= '0;
      r_pend_vld    <= 1'b0;
      r_act_period  <= CNT_W'(DEF_PERIOD);
      r_act_high    <= CNT_W'(DEF_HIGH);
      r_cfg_ack     <= 1'b0;
    end else begin
      r_act_period <= w_act_period_nxt;
      r_act_high   <= w_act_high_nxt;
      r_cfg_ack    <= w_apply | w_idle_load;
      if (w_run_load) begin
        r_pend_period <= w_eff_period;
        r_pend_high   <= w_eff_high;
        r_pend_vld    <= 1'b1;
      end else if (w_apply) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign o_act_period = r_act_period;
  assign o_act_high   = r_act_high;
  assign o_nxt_high_c = w_act_high_nxt;
  assign o_cfg_ack    = r_cfg_ack;

endmodule

// File: rtl/gate_pulse_gen.sv
// Programmable gate/pulse generator with glitch-free double-buffered config.
// Optional GATE_GEN_ONESHOT_EN adds a oneshot input: one period per 0->1 edge of enable.
module gate_pulse_gen
  import gate_gen_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned CYC_W      = 32,
  parameter int unsigned MIN_PERIOD = GG_MIN_PERIOD,
  parameter int unsigned DEF_PERIOD = 2,
  parameter int unsigned DEF_HIGH   = 1
) (
  input  logic             sys_count_clk,
  input  logic             rst_n,
  input  logic             enable,
`ifdef GATE_GEN_ONESHOT_EN
  input  logic             oneshot,
`endif
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             cfg_load,
  output logic             cfg_ack,
  output logic             gate_out,
  output logic             period_start,
  output logic [CYC_W-1:0] cycle_count,
  output logic             busy
);

  gate_state_t      r_state;
  gate_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] w_phase_nxt;
  logic [CNT_W-1:0] w_phase_inc;
  logic             r_gate;
  logic             w_gate_nxt;
  logic             r_period_start;
  logic             w_period_start_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic [CYC_W-1:0] r_cycle_count;
  logic [CYC_W-1:0] w_cycle_count_nxt;

  logic [CNT_W-1:0] w_act_period;
  logic [CNT_W-1:0] w_act_high;
  logic [CNT_W-1:0] w_nxt_high;
  logic             w_cfg_ack;
  logic             w_in_run;
  logic             w_boundary;
  logic             w_start_ok;
  logic             w_run_on;
  logic             w_new_period;

`ifdef GATE_GEN_ONESHOT_EN
  logic r_en_q;

  always_ff @(posedge sys_count_clk or negedge rst_n) begin
    if (!rst_n) r_en_q <= 1'b0;
    else        r_en_q <= enable;
  end

  assign w_start_ok = oneshot ? (enable & ~r_en_q) : enable;
  assign w_run_on   = enable & ~oneshot;
`else
  assign w_start_ok = enable;
  assign w_run_on   = enable;
`endif

  gate_cfg_shadow #(
    .CNT_W      (CNT_W),
    .MIN_PERIOD (MIN_PERIOD),
    .DEF_PERIOD (DEF_PERIOD),
    .DEF_HIGH   (DEF_HIGH)
  ) u_cfg_shadow (
    .sys_count_clk (sys_count_clk),
    .rst_n         (rst_n),
    .i_load        (cfg_load),
    .i_idle        (~w_in_run),
    .i_boundary    (w_boundary),
    .i_period      (cfg_period),
    .i_high        (cfg_high),
    .o_act_period  (w_act_period),
    .o_act_high    (w_act_high),
    .o_nxt_high_c  (w_nxt_high),
    .o_cfg_ack     (w_cfg_ack)
  );

  assign w_in_run     = (r_state == ST_RUN);
  assign w_boundary   = w_in_run && (r_phase == (w_act_period - CNT_W'(1)));
  assign w_new_period = (~w_in_run & w_start_ok) | (w_boundary & w_run_on);
  assign w_phase_inc  = r_phase + CNT_W'(1);

  always_ff @(posedge sys_count_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_boundary && !w_run_on) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next phase/gate/pulse values; a new period takes its high time from the config active after this edge.
  always_comb begin
    w_phase_nxt        = '0;
    w_gate_nxt         = 1'b0;
    w_busy_nxt         = 1'b0;
    w_period_start_nxt = w_new_period;
    w_cycle_count_nxt  = r_cycle_count;
    if (w_boundary) w_cycle_count_nxt = r_cycle_count + CYC_W'(1);
    if (w_new_period) begin
      w_gate_nxt = (w_nxt_high != '0);
      w_busy_nxt = 1'b1;
    end else if (w_in_run && !w_boundary) begin
      w_phase_nxt = w_phase_inc;
      w_gate_nxt  = (w_phase_inc < w_act_high);
      w_busy_nxt  = 1'b1;
    end
  end

  always_ff @(posedge sys_count_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase        <= '0;
      r_gate         <= 1'b0;
      r_period_start <= 1'b0;
      r_busy         <= 1'b0;
      r_cycle_count  <= '0;
    end else begin
      r_phase        <= w_phase_nxt;
      r_gate         <= w_gate_nxt;
      r_period_start <= w_period_start_nxt;
      r_busy         <= w_busy_nxt;
      r_cycle_count  <= w_cycle_count_nxt;
    end
  end

  assign cfg_ack      = w_cfg_ack;
  assign gate_out     = r_gate;
  assign period_start = r_period_start;
  assign cycle_count  = r_cycle_count;
  assign busy         = r_busy;

endmodule

// File: tb/tb_gate_pulse_gen.sv
// Scoreboard bench for gate_pulse_gen (CYC_W=4 so the cycle counter wrap is reachable).
module tb_gate_pulse_gen;

  logic        sys_count_clk = 1'b0;
  logic        rst_n         = 1'b1;
  logic        enable        = 1'b0;
  logic        cfg_load      = 1'b0;
  logic [31:0] cfg_period    = '0;
  logic [31:0] cfg_high      = '0;
  logic        cfg_ack;
  logic        gate_out;
  logic        period_start;
  logic [3:0]  cycle_count;
  logic        busy;
`ifdef GATE_GEN_ONESHOT_EN
  logic        oneshot       = 1'b0;
`endif

  typedef struct packed {
    logic       gate;
    logic       ps;
    logic       busy;
    logic       ack;
    logic [3:0] cnt;
  } exp_t;

  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string cur_test = "init";

  gate_pulse_gen #(.CYC_W(4)) dut (
    .sys_count_clk (sys_count_clk),
    .rst_n         (rst_n),
    .enable        (enable),
`ifdef GATE_GEN_ONESHOT_EN
    .oneshot       (oneshot),
`endif
    .cfg_period    (cfg_period),
    .cfg_high      (cfg_high),
    .cfg_load      (cfg_load),
    .cfg_ack       (cfg_ack),
    .gate_out      (gate_out),
    .period_start  (period_start),
    .cycle_count   (cycle_count),
    .busy          (busy)
  );

  always #5 sys_count_clk = ~sys_count_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", cur_test, tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit g, input bit ps, input bit b, input bit a, input int cnt);
    exp_t e;
    e.gate = g;
    e.ps   = ps;
    e.busy = b;
    e.ack  = a;
    e.cnt  = 4'(cnt % 16);
    return e;
  endfunction

  task automatic chk_all_zero();
    chk("rst_gate", 32'(gate_out), 32'd0);
    chk("rst_ps",   32'(period_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack",  32'(cfg_ack), 32'd0);
    chk("rst_cnt",  32'(cycle_count), 32'd0);
  endtask

  // One clock: outputs of this edge are compared against the oldest queued expectation.
  task automatic tick();
    exp_t e;
    @(posedge sys_count_clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("gate", 32'(gate_out), 32'(e.gate));
      chk("ps",   32'(period_start), 32'(e.ps));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("ack",  32'(cfg_ack), 32'(e.ack));
      chk("cnt",  32'(cycle_count), 32'(e.cnt));
    end
  endtask

  task automatic idle(input int n, input bit ack, input int cnt);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(mk(1'b0, 1'b0, 1'b0, ack && (i == 0), cnt));
      tick();
    end
  endtask

  // One full period of P/H; optional config load or enable drop before the edge producing phase i.
  task automatic period(input int p, input int h, input bit ack, input int cnt,
                        input int load_at = -1, input int lp = 0, input int lh = 0,
                        input int drop_at = -1);
    for (int i = 0; i < p; i++) begin
      cfg_load = (i == load_at);
      if (i == load_at) begin
        cfg_period = 32'(lp);
        cfg_high   = 32'(lh);
      end
      if (i == drop_at) enable = 1'b0;
      sb_q.push_back(mk(i < h, i == 0, 1'b1, ack && (i == 0), cnt));
      tick();
    end
    cfg_load = 1'b0;
  endtask

  initial begin
    cur_test = "reset";
    #2 rst_n = 1'b0;
    #1 chk_all_zero();
    repeat (2) @(posedge sys_count_clk);
    #1 rst_n = 1'b1;
    idle(2, 1'b0, 0);

    cur_test = "basic";
    cfg_period = 32'd10;
    cfg_high   = 32'd4;
    cfg_load   = 1'b1;
    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 0));
    tick();
    cfg_load = 1'b0;
    enable   = 1'b1;
    period(10, 4, 1'b0, 0);
    period(10, 4, 1'b0, 1);
    period(10, 4, 1'b0, 2);

    cur_test = "reconfig";
    period(10, 4, 1'b0, 3, 3, 6, 3);
    period(6, 3, 1'b1, 4, 0, 1, 5);

    cur_test = "clamp";
    period(2, 1, 1'b1, 5);
    period(2, 1, 1'b0, 6, 1, 8, 0);
    period(8, 0, 1'b1, 7);
    period(8, 0, 1'b0, 8, 3, 10, 4);

    cur_test = "stop";
    period(10, 4, 1'b1, 9, -1, 0, 0, 2);
    idle(3, 1'b0, 10);

    cur_test = "async_rst";
    enable = 1'b1;
    sb_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 10));
    tick();
    sb_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 10));
    tick();
    #2 rst_n = 1'b0;
    #1 chk_all_zero();
    enable = 1'b0;
    @(posedge sys_count_clk);
    #1 rst_n = 1'b1;
    idle(1, 1'b0, 0);

    cur_test = "wrap";
    enable = 1'b1;
    for (int k = 0; k < 18; k++) period(2, 1, 1'b0, k);
    enable = 1'b0;
    idle(2, 1'b0, 2);

`ifdef GATE_GEN_ONESHOT_EN
    cur_test = "oneshot";
    oneshot = 1'b1;
    enable  = 1'b1;
    period(2, 1, 1'b0, 2);
    idle(3, 1'b0, 3);
    enable = 1'b0;
    idle(1, 1'b0, 3);
    enable = 1'b1;
    period(2, 1, 1'b0, 3);
    idle(1, 1'b0, 4);
    oneshot = 1'b0;
    enable  = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
